// File: rtl/regfile_dump_ctrl.sv
// Streams the register file out over a byte sink while the CPU is halted.
// Each register is sent LSB byte first, one register read per LOAD cycle.
module regfile_dump_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NREGS      = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_halted,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    input  logic                  i_tx_ready,
    output logic                  o_rf_sel,
    output logic [4:0]            o_rf_addr,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [4:0]    LAST_REG  = 5'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                state;
    logic [4:0]            addr;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  aborted_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            shift     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && i_halted) begin
                        state <= LOAD;
                        addr  <= '0;
                    end
                end
                LOAD: begin
                    if (!i_halted) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        shift <= i_rf_data;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    // A byte handed over in the abort cycle is still shifted out.
                    if (i_tx_ready) begin
                        shift <= shift >> 8;
                        cnt   <= cnt + 1'b1;
                    end
                    if (!i_halted) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (i_tx_ready && cnt == LAST_BYTE) begin
                        if (addr == LAST_REG) begin
                            state <= DONE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; reset forces them low immediately.
    always_comb begin
        o_rf_sel   = !i_rst && (state == LOAD || state == SEND);
        o_rf_addr  = o_rf_sel ? addr : 5'd0;
        o_tx_valid = !i_rst && (state == SEND);
        o_tx_data  = o_tx_valid ? shift[7:0] : 8'd0;
        o_busy     = !i_rst && (state != IDLE);
        o_done     = !i_rst && (state == DONE);
        o_aborted  = !i_rst && aborted_q;
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: stimulus pushes expected bytes,
// a negedge monitor pops them on every accepted transfer.
module tb_regfile_dump_ctrl;

    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_halted = 1'b1;
    logic          i_tx_ready = 1'b1;
    logic [DW-1:0] i_rf_data;
    logic          o_rf_sel, o_tx_valid, o_busy, o_done, o_aborted;
    logic [4:0]    o_rf_addr;
    logic [7:0]    o_tx_data;

    always #5 clk = ~clk;

    // Regfile model: rK = 0x11223300 + K, r0 hardwired to zero.
    assign i_rf_data = (o_rf_addr == 5'd0) ? 32'd0 : (32'h11223300 + {27'd0, o_rf_addr});

    regfile_dump_ctrl #(.DATA_WIDTH(DW), .NREGS(NR)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_halted(i_halted),
        .i_rf_data(i_rf_data), .i_tx_ready(i_tx_ready),
        .o_rf_sel(o_rf_sel), .o_rf_addr(o_rf_addr), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] expq[$];
    bit         mon_en = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'd0;

    int first_busy, last_busy, last_sel, sel_cnt, done_cnt, done_cyc, ab_cnt, ab_cyc;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [17:0] all_outs();
        return {o_rf_sel, o_rf_addr, o_tx_data, o_tx_valid, o_busy, o_done, o_aborted};
    endfunction

    // Expected stream: r0 -> 00 00 00 00, rK -> K 33 22 11.
    task automatic push_dump(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            case (i % 4)
                0:       b = 8'(i / 4);
                1:       b = 8'h33;
                2:       b = 8'h22;
                default: b = 8'h11;
            endcase
            if (i / 4 == 0) b = 8'h00;
            expq.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_tx_valid && i_tx_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_extra: got byte %0h, required none", o_tx_data);
                end else begin
                    chk("tx_byte", longint'(o_tx_data), longint'(expq.pop_front()));
                end
            end
            if (prev_hold && o_tx_valid) chk("tx_stable", longint'(o_tx_data), longint'(prev_data));
            if (!o_tx_valid) chk("tx_data_idle", longint'(o_tx_data), 0);
            if (!o_rf_sel) chk("rf_addr_idle", longint'(o_rf_addr), 0);
            prev_hold <= o_tx_valid && !i_tx_ready;
            prev_data <= o_tx_data;
        end
    end

    // One scenario: start in cycle 0, optional abort/reset/restart cycles.
    task automatic run(input int abort_at, input int rst_at, input int restart_at,
                       input bit toggle, input int ncyc);
        first_busy = -1; last_busy = -1; last_sel = -1; sel_cnt = 0;
        done_cnt = 0; done_cyc = -1; ab_cnt = 0; ab_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            i_start    = (c == 0) || (c == restart_at);
            i_halted   = !(abort_at >= 0 && c >= abort_at);
            i_rst      = (rst_at >= 0 && c == rst_at);
            i_tx_ready = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            if (o_busy) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (o_rf_sel) begin
                sel_cnt++;
                last_sel = c;
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (o_aborted) begin
                ab_cnt++;
                if (ab_cyc < 0) ab_cyc = c;
            end
            if (rst_at >= 0 && (c == rst_at || c == rst_at + 1))
                chk("rst_outputs", longint'(all_outs()), 0);
        end
        i_start = 1'b0; i_halted = 1'b1; i_rst = 1'b0; i_tx_ready = 1'b1;
        chk("bytes_left", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", longint'(all_outs()), 0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        mon_en = 1'b1;

        // Full dump, sink always ready.
        push_dump(128);
        run(-1, -1, -1, 1'b0, 180);
        chk("full_first_busy", first_busy, 1);
        chk("full_last_busy", last_busy, 161);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_done_cyc", done_cyc, 161);
        chk("full_aborted", ab_cnt, 0);

        // Ready high only on even cycles: 8 cycles per register, done at 257.
        push_dump(128);
        run(-1, -1, -1, 1'b1, 300);
        chk("toggle_done_cnt", done_cnt, 1);
        chk("toggle_done_cyc", done_cyc, 257);

        // Start while not halted is ignored.
        run(0, -1, -1, 1'b0, 20);
        chk("nohalt_busy", first_busy, -1);
        chk("nohalt_sel", sel_cnt, 0);
        chk("nohalt_aborted", ab_cnt, 0);

        // Halted drops during r5 byte 2 (cycle 29); that byte still goes out.
        push_dump(23);
        run(29, -1, -1, 1'b0, 60);
        chk("abort_cnt", ab_cnt, 1);
        chk("abort_cyc", ab_cyc, 30);
        chk("abort_last_busy", last_busy, 29);
        chk("abort_last_sel", last_sel, 29);
        chk("abort_done", done_cnt, 0);

        // Reset during r10 byte 1 (cycle 53): only r0..r9 plus r10 byte 0 sent.
        push_dump(41);
        run(-1, 53, -1, 1'b0, 80);
        chk("rst_last_busy", last_busy, 52);
        chk("rst_done", done_cnt, 0);

        // Start coincident with reset is ignored.
        run(-1, 0, -1, 1'b0, 20);
        chk("rststart_busy", first_busy, -1);

        // Fresh dump from r0 after reset, with a second start mid-dump.
        push_dump(128);
        run(-1, -1, 50, 1'b0, 180);
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_done_cyc", done_cyc, 161);
        chk("restart_last_busy", last_busy, 161);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
